// File: rtl/seg_scan_if.sv
// Handshake/bus bundle between score logic and the seven-segment scan controller.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic                    lz_en;
  logic [3:0]              bin_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;
  logic                    pending;

  modport master (
    output value_in, load, lz_en,
    input  bin_out, an, frame_done, pending
  );

  modport slave (
    input  value_in, load, lz_en,
    output bin_out, an, frame_done, pending
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Scans NUM_DIGITS common-anode digits through one shared decoder with a guard gap per digit.
// Outputs registered one cycle behind state; new values apply only at frame wrap (no tearing).
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int MAX_CNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {DRIVE, GUARD} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           div_cnt, div_cnt_nxt;
  logic [IW-1:0]           digit_idx, digit_idx_nxt;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] disp_reg, pend_reg;
  logic                    pend_flag;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   an_nxt, an_reg;
  logic [3:0]              bin_nxt, bin_reg;
  logic                    frame_done_reg;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign nib[g] = disp_reg[4*g +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DRIVE;
      div_cnt   <= '0;
      digit_idx <= '0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_cnt_nxt;
      digit_idx <= digit_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    div_cnt_nxt   = div_cnt + 1'b1;
    digit_idx_nxt = digit_idx;
    boundary      = 1'b0;
    case (state)
      DRIVE: begin
        if (div_cnt == DRIVE_LAST) begin
          div_cnt_nxt = '0;
          state_nxt   = GUARD;
        end
      end
      GUARD: begin
        if (div_cnt == GUARD_LAST) begin
          div_cnt_nxt = '0;
          state_nxt   = DRIVE;
          if (digit_idx == IDX_LAST) begin
            digit_idx_nxt = '0;
            boundary      = 1'b1;
          end else begin
            digit_idx_nxt = digit_idx + 1'b1;
          end
        end
      end
    endcase
  end

  // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    logic zero_hi;
    zero_hi = 1'b1;
    blank   = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_hi  = zero_hi & (nib[i] == 4'd0);
      blank[i] = zero_hi;
    end
  end

  always_comb begin
    an_nxt  = '1;
    bin_nxt = bin_reg;
    if (state == DRIVE) begin
      bin_nxt = nib[digit_idx];
      if (!(bus.lz_en && blank[digit_idx]))
        an_nxt[digit_idx] = 1'b0;
    end
  end

  // A load coinciding with the wrap still lets the old pending value reach the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_reg       <= '0;
      pend_reg       <= '0;
      pend_flag      <= 1'b0;
      an_reg         <= '1;
      bin_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      if (bus.load)
        pend_reg <= bus.value_in;
      if (boundary && pend_flag)
        disp_reg <= pend_reg;
      if (bus.load)
        pend_flag <= 1'b1;
      else if (boundary)
        pend_flag <= 1'b0;
      an_reg         <= an_nxt;
      bin_reg        <= bin_nxt;
      frame_done_reg <= boundary;
    end
  end

  assign bus.an         = an_reg;
  assign bus.bin_out    = bin_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.pending    = pend_flag;
endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: 4 digits, 4-cycle drive, 1-cycle guard, 20-cycle frame.
module tb_seg_scan_controller;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;
  localparam int FRAME = ND * (RD + GC);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   k = 0;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_controller #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // Advance n cycles after reset release, checking every output against the expected frame pattern.
  task automatic run_cycles(input int n, input logic [15:0] disp, input logic [3:0] blank,
                            input logic pend);
    for (int c = 0; c < n; c++) begin
      int p, d, s;
      logic [3:0] exp_an;
      logic [3:0] exp_bin;
      @(posedge clk);
      @(negedge clk);
      k++;
      p = (k - 1) % FRAME;
      d = p / (RD + GC);
      s = p % (RD + GC);
      exp_an = 4'hF;
      if (s < RD && !blank[d]) exp_an[d] = 1'b0;
      check_val("an", bus.an, exp_an);
      check_val("frame_done", bus.frame_done, (k % FRAME) == 0);
      check_val("pending", bus.pending, pend);
      if (s < RD && !blank[d]) begin
        exp_bin = disp[4*d +: 4];
        check_val("bin_out", bus.bin_out, exp_bin);
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [15:0] disp, input logic [3:0] blank);
    bus.value_in = v;
    bus.load     = 1'b1;
    run_cycles(1, disp, blank, 1'b1);
    bus.load     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", k);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.value_in = '0;
    bus.load     = 1'b0;
    bus.lz_en    = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_an", bus.an, 4'hF);
    check_val("rst_bin", bus.bin_out, 4'h0);
    check_val("rst_frame_done", bus.frame_done, 1'b0);
    check_val("rst_pending", bus.pending, 1'b0);
    rst = 1'b0;
    k = 0;

    // 1: free-running scan of zeros
    run_cycles(20, 16'h0000, 4'b0000, 1'b0);

    // 2: mid-frame load of 0x1234
    run_cycles(7, 16'h0000, 4'b0000, 1'b0);
    pulse_load(16'h1234, 16'h0000, 4'b0000);
    run_cycles(11, 16'h0000, 4'b0000, 1'b1);
    run_cycles(1, 16'h0000, 4'b0000, 1'b0);
    run_cycles(20, 16'h1234, 4'b0000, 1'b0);

    // 3: last load in a frame wins
    run_cycles(3, 16'h1234, 4'b0000, 1'b0);
    pulse_load(16'h1111, 16'h1234, 4'b0000);
    run_cycles(5, 16'h1234, 4'b0000, 1'b1);
    pulse_load(16'h2222, 16'h1234, 4'b0000);
    run_cycles(9, 16'h1234, 4'b0000, 1'b1);
    run_cycles(1, 16'h1234, 4'b0000, 1'b0);

    // 4: load in the boundary cycle; disp 0, pend 0x9999
    run_cycles(2, 16'h2222, 4'b0000, 1'b0);
    pulse_load(16'h0000, 16'h2222, 4'b0000);
    run_cycles(16, 16'h2222, 4'b0000, 1'b1);
    run_cycles(1, 16'h2222, 4'b0000, 1'b0);
    run_cycles(4, 16'h0000, 4'b0000, 1'b0);
    pulse_load(16'h9999, 16'h0000, 4'b0000);
    run_cycles(14, 16'h0000, 4'b0000, 1'b1);
    pulse_load(16'h5555, 16'h0000, 4'b0000);
    run_cycles(19, 16'h9999, 4'b0000, 1'b1);
    run_cycles(1, 16'h9999, 4'b0000, 1'b0);

    // 5: leading-zero blanking of 0x0070, then of 0x0000
    run_cycles(2, 16'h5555, 4'b0000, 1'b0);
    pulse_load(16'h0070, 16'h5555, 4'b0000);
    run_cycles(16, 16'h5555, 4'b0000, 1'b1);
    run_cycles(1, 16'h5555, 4'b0000, 1'b0);
    bus.lz_en = 1'b1;
    run_cycles(2, 16'h0070, 4'b1100, 1'b0);
    pulse_load(16'h0000, 16'h0070, 4'b1100);
    run_cycles(16, 16'h0070, 4'b1100, 1'b1);
    run_cycles(1, 16'h0070, 4'b1100, 1'b0);
    run_cycles(20, 16'h0000, 4'b1110, 1'b0);
    bus.lz_en = 1'b0;

    // 6: async reset during the guard slot of digit 2 with a load pending
    run_cycles(2, 16'h0000, 4'b0000, 1'b0);
    pulse_load(16'hABCD, 16'h0000, 4'b0000);
    run_cycles(11, 16'h0000, 4'b0000, 1'b1);
    rst = 1'b1;
    #1;
    check_val("arst_an", bus.an, 4'hF);
    check_val("arst_pending", bus.pending, 1'b0);
    check_val("arst_bin", bus.bin_out, 4'h0);
    check_val("arst_frame_done", bus.frame_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_val("arst_hold_an", bus.an, 4'hF);
    rst = 1'b0;
    k = 0;
    run_cycles(20, 16'h0000, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
